// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared opcode/funct constants, exception codes and mult/div predecode helper.
package if_id_queue_pkg;
  localparam int ECW_DEFAULT = 5;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  typedef enum logic [ECW_DEFAULT-1:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;
  function automatic logic is_md_funct(input logic [5:0] f);
    return f inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction
endpackage

// File: rtl/if_id_queue_md_predecode.sv
// if_id_md_predecode: flags SPECIAL-opcode mult/div/hi/lo instructions for the mult/div unit.
module if_id_md_predecode
  import if_id_queue_pkg::*;
(
  input  logic [31:0] instr,
  output logic        md
);
  logic unused_bits;
  assign unused_bits = ^instr[25:6];
  assign md = (instr[31:26] == OP_SPECIAL) && is_md_funct(instr[5:0]);
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry IF/ID instruction FIFO; IF_ID_QUEUE_PREDECODE_EN stores a per-entry mult/div flag.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int ECW   = ECW_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_pc,
  input  logic [DW-1:0]              in_instr,
  input  logic [ECW-1:0]             in_exccode,
  input  logic                       in_delay,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_pc,
  output logic [DW-1:0]              out_instr,
  output logic [ECW-1:0]             out_exccode,
  output logic                       out_delay,
  output logic                       out_md,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DW-1:0]  pc_mem    [DEPTH];
  logic [DW-1:0]  instr_mem [DEPTH];
  logic [ECW-1:0] exc_mem   [DEPTH];
  logic [DEPTH-1:0] delay_mem;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic push, pop;
  logic [DW-1:0] instr_s;
  assign in_ready  = count != CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // faulting fetches enter decode as a nop so no side effects leak through
  assign instr_s   = (in_exccode != '0) ? '0 : in_instr;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= instr_s;
      exc_mem[wr_ptr]   <= in_exccode;
      delay_mem[wr_ptr] <= in_delay;
    end
  end
  assign out_pc      = out_valid ? pc_mem[rd_ptr] : '0;
  assign out_instr   = out_valid ? instr_mem[rd_ptr] : '0;
  assign out_exccode = out_valid ? exc_mem[rd_ptr] : '0;
  assign out_delay   = out_valid && delay_mem[rd_ptr];
`ifdef IF_ID_QUEUE_PREDECODE_EN
  logic md_in;
  logic [DEPTH-1:0] md_mem;
  if_id_md_predecode u_md_predecode (
    .instr(instr_s[31:0]),
    .md   (md_in)
  );
  always_ff @(posedge clk) begin
    if (push) md_mem[wr_ptr] <= md_in;
  end
  assign out_md = out_valid && md_mem[rd_ptr];
`else
  assign out_md = 1'b0;
`endif
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed plan plus random traffic, scoreboard of expected entries checked at every pop.
module tb_if_id_queue;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        d;
    logic        md;
  } ent_t;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0, in_delay = 0;
  logic [31:0] in_pc = 0, in_instr = 0;
  logic [4:0] in_exccode = 0;
  logic in_ready, out_valid, out_delay, out_md;
  logic [31:0] out_pc, out_instr;
  logic [4:0] out_exccode;
  logic [2:0] count;
  ent_t sb[$];
  int n = 0;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  if_id_queue #(.DEPTH(DEPTH), .DW(32), .ECW(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .in_exccode(in_exccode), .in_delay(in_delay),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_exccode(out_exccode), .out_delay(out_delay), .out_md(out_md), .count(count)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic ent_t model(input logic [31:0] pc, input logic [31:0] ins,
                                 input logic [4:0] exc, input logic d);
    ent_t e;
    e.pc = pc;
    e.instr = (exc != 0) ? 32'h0 : ins;
    e.exc = exc;
    e.d = d;
`ifdef IF_ID_QUEUE_PREDECODE_EN
    e.md = (e.instr[31:26] == 6'h00) &&
           (e.instr[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b});
`else
    e.md = 1'b0;
`endif
    return e;
  endfunction
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic [4:0] exc, input logic d, input logic ordy,
                      input logic fl, input logic rs);
    logic acc, pp;
    in_valid = v; in_pc = pc; in_instr = ins; in_exccode = exc; in_delay = d;
    out_ready = ordy; flush = fl; reset = rs;
    if (rs || fl) begin
      sb.delete();
      n = 0;
    end else begin
      acc = v && (n < DEPTH);
      pp = ordy && (n > 0);
      if (acc) sb.push_back(model(pc, ins, exc, d));
      n = n + int'(acc) - int'(pp);
    end
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(n));
    check("in_ready", 32'(in_ready), 32'(n != DEPTH));
    check("out_valid", 32'(out_valid), 32'(n != 0));
  endtask
  task automatic push1(input logic [31:0] pc, input logic [31:0] ins, input logic [4:0] exc);
    step(1, pc, ins, exc, pc[2], 0, 0, 0);
  endtask
  task automatic pop1();
    step(0, 0, 0, 0, 0, 1, 0, 0);
  endtask
  always @(negedge clk) begin
    if (!reset && !flush) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("sb_underflow", 32'(out_valid), 32'(0));
        else begin
          ent_t e;
          e = sb.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_instr", out_instr, e.instr);
          check("out_exccode", 32'(out_exccode), 32'(e.exc));
          check("out_delay", 32'(out_delay), 32'(e.d));
          check("out_md", 32'(out_md), 32'(e.md));
        end
      end else if (!out_valid) begin
        check("empty_bubble", {out_pc ^ out_instr, 32'(out_exccode) | 32'(out_delay) | 32'(out_md)} != 0 ? 32'(1) : 32'(0), 32'(0));
      end
    end
  end
  initial begin
    logic [31:0] ins;
    logic [4:0] exc;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) push1(32'h3000 + 32'(4 * i), 32'h00430821, 0);
    for (int i = 0; i < 4; i++) pop1();
    for (int i = 0; i < 10; i++) step(1, 32'h3100 + 32'(4 * i), 32'h24020001, 0, 0, 1, 0, 0);
    pop1();
    push1(32'h3001, 32'h8c010000, 5'd4);
    pop1();
    push1(32'h3200, 32'h00430018, 0);
    push1(32'h3204, 32'h00001010, 0);
    push1(32'h3208, 32'h00430821, 0);
    for (int i = 0; i < 3; i++) pop1();
    for (int i = 0; i < 3; i++) push1(32'h3300 + 32'(4 * i), 32'h0000001a, 0);
    step(1, 32'h330c, 32'h00000019, 0, 0, 0, 1, 0);
    pop1();
    push1(32'h3400, 32'h00000012, 0);
    push1(32'h3404, 32'h00000013, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    push1(32'h3408, 32'h0000001b, 0);
    pop1();
    for (int i = 0; i < 2000; i++) begin
      ins = $urandom;
      if ($urandom % 3 == 0) ins = {6'h00, ins[25:6], 2'b01, 1'b0, 3'($urandom)};
      exc = ($urandom % 5 == 0) ? 5'(($urandom % 2) ? 4 : (($urandom % 2) ? 10 : 12)) : 5'd0;
      step(($urandom % 4) != 0, $urandom, ins, exc, 1'($urandom), ($urandom % 3) != 0,
           ($urandom % 60) == 0, ($urandom % 97) == 0);
    end
    for (int i = 0; i <= DEPTH && n > 0; i++) pop1();
    check("drained", 32'(n), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised instruction queue between fetch (IF) and decode (ID) that replaces the single-entry IF/ID latch. It buffers up to DEPTH fetched instructions with their PC, exception code and delay-slot flag. Each entry also carries a pre-decoded mult/div-unit flag. Fetch and decode are decoupled by a valid/ready handshake, so decode stalls no longer freeze fetch until the queue fills. A synchronous flush empties the queue on exception entry, eret or branch redirect.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- DW, 32, PC/instruction width
- ECW, 5, exception-code width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous clear of all entries
- in_valid  in  1  fetch offers an entry
- in_ready  out  1  queue can accept an entry (= !full)
- in_pc  in  DW  PC of fetched instruction
- in_instr  in  DW  fetched instruction word
- in_exccode  in  ECW  fetch exception code (0 = none)
- in_delay  in  1  instruction sits in a branch delay slot
- out_valid  out  1  head entry present
- out_ready  in  1  decode consumes head
- out_pc  out  DW  head PC
- out_instr  out  DW  head instruction
- out_exccode  out  ECW  head exception code
- out_delay  out  1  head delay-slot flag
- out_md  out  1  head is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- count  out  $clog2(DEPTH+1)  occupancy

## Operation
- Storage is a circular buffer with rd_ptr, wr_ptr and count. The pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push occurs when in_valid && in_ready. It writes {pc, instr', exccode, delay, md} at wr_ptr and advances wr_ptr.
- Pop occurs when out_valid && out_ready. It advances rd_ptr.
- in_ready = (count != DEPTH). out_valid = (count != 0).
- The in_ready definition is fixed. When the queue is full, a push is refused even if a pop happens in the same cycle. There is no full-bypass.
- Simultaneous push and pop on a non-empty, non-full queue leaves count unchanged.
- There is no empty-bypass. A pushed entry becomes visible on the cycle after the push.
- Exception sanitising: if in_exccode != 0, instr' = 0 (nop); otherwise instr' = in_instr. PC, exccode and delay are stored unchanged.
- md is computed from instr' at push time and stored with the entry. It is 1 when opcode == 0 and funct ∈ {0x10, 0x11, 0x12, 0x13, 0x18, 0x19, 0x1a, 0x1b}.
- When the queue is empty, out_pc, out_instr, out_exccode, out_delay and out_md are driven to 0, so decode sees a nop bubble.
- Flush sets count, rd_ptr and wr_ptr to 0. Any push or pop in the same cycle is discarded. Flush takes priority over reset-free operation.
- Reset has the same effect as flush. Entry contents need not be cleared.

## Timing
- Reset and flush values: count = 0, in_ready = 1, out_valid = 0, and every out_* data output = 0. All take effect from the cycle after the reset/flush edge.
- Latency from push to out_valid is 1 cycle.
- With continuous push and pop, throughput is 1 entry per cycle.
- The out_* data outputs are combinational reads of the head entry, muxed to 0 when empty.
- in_ready and out_valid depend only on registered count. There is no combinational path from in_valid or out_ready.
- Reset asserted mid-stream empties the queue on the next edge. The first push after reset is accepted in the first cycle with reset low.

## Configuration
- IF_ID_QUEUE_PREDECODE_EN defined: the md bit is stored per entry and out_md is driven from it.
- IF_ID_QUEUE_PREDECODE_EN undefined: the md storage and the predecoder are removed, and out_md is tied to 0.
- All other behaviour is identical in both configurations.

## Structure
- The shared package holds:
  - the SPECIAL opcode constant (6'h00);
  - the funct constants MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV and DIVU;
  - the ECW default and the exception-code enum (Int = 0, AdEL = 4, RI = 10, Ov = 12).
- Sub-module if_id_md_predecode is combinational: instr → md. It is instantiated only under IF_ID_QUEUE_PREDECODE_EN.

## Test plan
- Fill: hold out_ready = 0 and push PCs 0x3000, 0x3004, 0x3008, 0x300c (DEPTH = 4). Expect count = 4 and in_ready = 0, and a 5th push is ignored. Then pop four times: out_pc follows 0x3000…0x300c in order and out_valid falls after the last pop.
- Streaming with wrap-around: keep in_valid and out_ready high for 10 cycles. Expect one pop per cycle after the first, count constant at 1, and PCs in order through the pointer wrap.
- Exception sanitising: push in_exccode = 4, in_instr = 0x8c010000, pc = 0x3001. Expect out_instr = 0, out_exccode = 4, out_pc = 0x3001 and out_md = 0.
- Predecode: push 0x00430018 (mult) and then 0x00001010 (mfhi). Expect out_md = 1 for both, and out_md = 0 for 0x00430821 (addu).
- Flush with push: with 3 entries queued, assert flush together with a push. Next cycle expect count = 0, out_valid = 0, out_instr = 0 and in_ready = 1.
- Reset mid-operation: with 2 entries queued, assert reset for 1 cycle. Expect all outputs at reset values. A push on the first cycle after reset appears at the head one cycle later.
